// File: rtl/gbsha_fir_pkg.sv
// Shared definitions for the gbsha FIR core: state encoding and width helpers.
package gbsha_fir_pkg;

    // Two-state controller: coefficient capture, then one-sample-per-clock filtering
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } fir_state_t;

    // Ceiling log2, usable in constant expressions (returns 0 for value <= 1)
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Accumulator width: a full signed product plus enough guard bits to sum every tap
    function automatic int acc_width(input int n_taps, input int bw_in);
        return 2 * bw_in + clog2(n_taps);
    endfunction

    // Width used for range comparison in the narrowing stage; one bit wider than
    // both the accumulator and the output so the limits and the sign are always representable
    function automatic int cmp_width(input int bw_acc, input int bw_out);
        return ((bw_acc > bw_out) ? bw_acc : bw_out) + 1;
    endfunction

endpackage

// File: rtl/gbsha_fir_narrow.sv
// Output narrowing for the FIR core: arithmetic right shift of the accumulator,
// then either clamp to the signed output range or keep the low output bits.
module gbsha_fir_narrow
    import gbsha_fir_pkg::*;
#(
    parameter int BW_acc    = 14,
    parameter int BW_out    = 8,
    parameter int OUT_SHIFT = 0,
    parameter int SATURATE  = 1
) (
    input  logic signed [BW_acc-1:0] acc,
    output logic signed [BW_out-1:0] y
);

    localparam int BW_cmp = cmp_width(BW_acc, BW_out);

    // Largest and smallest values representable in BW_out signed bits, held at compare width
    localparam logic signed [BW_cmp-1:0] SAT_MAX =
        {{(BW_cmp - BW_out + 1){1'b0}}, {(BW_out - 1){1'b1}}};
    localparam logic signed [BW_cmp-1:0] SAT_MIN =
        {{(BW_cmp - BW_out + 1){1'b1}}, {(BW_out - 1){1'b0}}};

    logic signed [BW_acc-1:0] shifted;
    logic signed [BW_cmp-1:0] wide;

    // Scale, sign-extend to compare width, then clamp or wrap into the output width
    always_comb begin
        shifted = acc >>> OUT_SHIFT;
        wide    = BW_cmp'(shifted);
        y       = wide[BW_out-1:0];
        if (SATURATE != 0) begin
            if (wide > SAT_MAX) begin
                y = SAT_MAX[BW_out-1:0];
            end else if (wide < SAT_MIN) begin
                y = SAT_MIN[BW_out-1:0];
            end
        end
    end

endmodule

// File: rtl/gbsha_fir_core.sv
// N-tap direct-form FIR core. After reset (or a reload request) the next N_TAPS
// words on x_in are taken as coefficients coeff[0..N_TAPS-1]; afterwards one
// sample per clock is filtered and the scaled, narrowed result is registered on y_out.
module gbsha_fir_core
    import gbsha_fir_pkg::*;
#(
    parameter int N_TAPS    = 4,
    parameter int BW_in     = 6,
    parameter int BW_out    = 8,
    parameter int OUT_SHIFT = 0,
    parameter int SATURATE  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [BW_in-1:0]  x_in,
    input  logic                     load,
    output logic signed [BW_out-1:0] y_out,
    output logic                     coeff_loaded
);

    localparam int BW_prod = 2 * BW_in;
    localparam int BW_acc  = acc_width(N_TAPS, BW_in);
    localparam int IDX_W   = clog2(N_TAPS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TAPS - 1);

    fir_state_t state;
    fir_state_t state_next;

    logic [IDX_W-1:0]          idx;
    logic signed [BW_in-1:0]   coeff [N_TAPS];
    logic signed [BW_in-1:0]   x_reg [N_TAPS];
    logic signed [BW_prod-1:0] prod  [N_TAPS];
    logic signed [BW_acc-1:0]  acc;
    logic signed [BW_out-1:0]  y_next;
    logic                      last_capture;
    logic                      shift_en;

    // Decode the two events that drive the datapath: final coefficient capture and a live sample
    always_comb begin
        last_capture = (state == ST_LOAD) && (idx == IDX_LAST);
        shift_en     = (state == ST_RUN) && !load;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave LOAD after the last capture, return to it on a reload request in RUN
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: begin
                if (last_capture) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    // Status output follows the state register directly
    always_comb begin
        coeff_loaded = (state == ST_RUN);
    end

    // Capture index walks 0..N_TAPS-1 during LOAD and rests at 0 otherwise,
    // so a reload always starts again at coeff[0]
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (state == ST_LOAD) begin
            if (last_capture) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            idx <= '0;
        end
    end

    // Coefficient bank is written only while loading; the load pin is not consulted here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_TAPS; k++) begin
                coeff[k] <= '0;
            end
        end else if (state == ST_LOAD) begin
            coeff[idx] <= x_in;
        end
    end

    // Sample delay line: shifts in RUN, cleared during LOAD and on the reload edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_TAPS; k++) begin
                x_reg[k] <= '0;
            end
        end else if (shift_en) begin
            x_reg[0] <= x_in;
            for (int k = 1; k < N_TAPS; k++) begin
                x_reg[k] <= x_reg[k-1];
            end
        end else begin
            for (int k = 0; k < N_TAPS; k++) begin
                x_reg[k] <= '0;
            end
        end
    end

    // Full-precision signed products and their sum; the guard bits rule out overflow
    always_comb begin
        acc = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            prod[k] = BW_prod'(x_reg[k]) * BW_prod'(coeff[k]);
            acc     = acc + BW_acc'(prod[k]);
        end
    end

    gbsha_fir_narrow #(
        .BW_acc   (BW_acc),
        .BW_out   (BW_out),
        .OUT_SHIFT(OUT_SHIFT),
        .SATURATE (SATURATE)
    ) u_narrow (
        .acc(acc),
        .y  (y_next)
    );

    // Output register: filtered value in RUN, forced to zero while loading or reloading
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_out <= '0;
        end else if (shift_en) begin
            y_out <= y_next;
        end else begin
            y_out <= '0;
        end
    end

endmodule

// File: tb/tb_gbsha_fir_core.sv
// Directed bench for gbsha_fir_core. Three instances share clock, reset and inputs:
// default settings, wrap instead of saturate, and a right shift of 2, so one
// stimulus sequence exercises all three narrowing behaviours.
module tb_gbsha_fir_core;

    logic              clk;
    logic              reset;
    logic signed [5:0] x_in;
    logic              load;

    logic signed [7:0] y_base;
    logic signed [7:0] y_wrap;
    logic signed [7:0] y_shift;
    logic              cl_base;
    logic              cl_wrap;
    logic              cl_shift;

    int check_count = 0;
    int pass_count  = 0;

    gbsha_fir_core dut_base (
        .clk         (clk),
        .reset       (reset),
        .x_in        (x_in),
        .load        (load),
        .y_out       (y_base),
        .coeff_loaded(cl_base)
    );

    gbsha_fir_core #(.SATURATE(0)) dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .x_in        (x_in),
        .load        (load),
        .y_out       (y_wrap),
        .coeff_loaded(cl_wrap)
    );

    gbsha_fir_core #(.OUT_SHIFT(2)) dut_shift (
        .clk         (clk),
        .reset       (reset),
        .x_in        (x_in),
        .load        (load),
        .y_out       (y_shift),
        .coeff_loaded(cl_shift)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one input word, let one rising edge take it, then settle 1 time unit past the edge
    task automatic applyStimulus(input int x, input bit ld);
        x_in = 6'(x);
        load = ld;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            $error("[TB] FAIL %s: observed 0x%02h, expected 0x%02h", tag, observed, expected);
        end
    endtask

    // Present four coefficient words; load is raised on word ld_pos (-1 for none)
    task automatic loadCoeffs(input int c0, input int c1, input int c2, input int c3, input int ld_pos);
        int c[4];
        c = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(c[i], (i == ld_pos));
        end
    endtask

    initial begin
        reset = 1'b1;
        x_in  = '0;
        load  = 1'b0;

        // Reset state, observed while reset is still held across an edge
        #12;
        checkOutput("reset_y", y_base, 8'h00);
        checkOutput("reset_cl", {7'd0, cl_base}, 8'h00);
        reset = 1'b0;

        // Test 1: coefficients 1,2,3,4 and an impulse -> 1,2,3,4,0 one edge after each
        loadCoeffs(1, 2, 3, 4, -1);
        checkOutput("t1_cl", {7'd0, cl_base}, 8'h01);
        applyStimulus(1, 1'b0);
        checkOutput("t1_y0", y_base, 8'h00);
        applyStimulus(0, 1'b0);
        checkOutput("t1_y1", y_base, 8'h01);
        applyStimulus(0, 1'b0);
        checkOutput("t1_y2", y_base, 8'h02);
        applyStimulus(0, 1'b0);
        checkOutput("t1_y3", y_base, 8'h03);
        applyStimulus(0, 1'b0);
        checkOutput("t1_y4", y_base, 8'h04);
        checkOutput("t1_y4_shift", y_shift, 8'h01);
        applyStimulus(0, 1'b0);
        checkOutput("t1_y5", y_base, 8'h00);

        // Test 2: difference filter 1,-1,0,0 with a step of 5, then a step down to -3
        applyStimulus(0, 1'b1);
        checkOutput("t2_reload_cl", {7'd0, cl_base}, 8'h00);
        loadCoeffs(1, -1, 0, 0, -1);
        checkOutput("t2_cl", {7'd0, cl_base}, 8'h01);
        applyStimulus(5, 1'b0);
        checkOutput("t2_y0", y_base, 8'h00);
        applyStimulus(5, 1'b0);
        checkOutput("t2_y1", y_base, 8'h05);
        applyStimulus(5, 1'b0);
        checkOutput("t2_y2", y_base, 8'h00);
        applyStimulus(5, 1'b0);
        checkOutput("t2_y3", y_base, 8'h00);
        applyStimulus(-3, 1'b0);
        checkOutput("t2_y4", y_base, 8'h00);
        applyStimulus(-3, 1'b0);
        checkOutput("t2_y5_neg", y_base, 8'hF8);

        // Test 3: coefficients -32 x4 (load raised mid-capture must be ignored), x=-32 held
        applyStimulus(0, 1'b1);
        loadCoeffs(-32, -32, -32, -32, 1);
        checkOutput("t3_cl", {7'd0, cl_base}, 8'h01);
        applyStimulus(-32, 1'b0);
        checkOutput("t3_y0", y_base, 8'h00);
        applyStimulus(-32, 1'b0);
        checkOutput("t3_y1_sat", y_base, 8'h7F);
        checkOutput("t3_y1_wrap", y_wrap, 8'h00);
        checkOutput("t3_y1_shift", y_shift, 8'h7F);
        applyStimulus(-32, 1'b0);
        applyStimulus(-32, 1'b0);
        applyStimulus(-32, 1'b0);
        checkOutput("t3_y4096_sat", y_base, 8'h7F);
        checkOutput("t3_y4096_wrap", y_wrap, 8'h00);
        checkOutput("t3_y4096_shift", y_shift, 8'h7F);
        // Switch to x=31 against the same coefficients
        applyStimulus(31, 1'b0);
        applyStimulus(31, 1'b0);
        applyStimulus(31, 1'b0);
        checkOutput("t3_y64_sat", y_base, 8'h40);
        checkOutput("t3_y64_wrap", y_wrap, 8'h40);
        checkOutput("t3_y64_shift", y_shift, 8'h10);
        applyStimulus(31, 1'b0);
        checkOutput("t3_ym1952_sat", y_base, 8'h80);
        checkOutput("t3_ym1952_wrap", y_wrap, 8'h60);
        checkOutput("t3_ym1952_shift", y_shift, 8'h80);
        applyStimulus(31, 1'b0);
        checkOutput("t3_ym3968_sat", y_base, 8'h80);
        checkOutput("t3_ym3968_wrap", y_wrap, 8'h80);
        checkOutput("t3_ym3968_shift", y_shift, 8'h80);

        // Test 4: coefficients 4 x4, x=3 held -> acc 48; shift by 2 gives 12
        applyStimulus(0, 1'b1);
        loadCoeffs(4, 4, 4, 4, -1);
        applyStimulus(3, 1'b0);
        checkOutput("t4_y0", y_shift, 8'h00);
        applyStimulus(3, 1'b0);
        checkOutput("t4_y12_base", y_base, 8'h0C);
        checkOutput("t4_y12_shift", y_shift, 8'h03);
        applyStimulus(3, 1'b0);
        applyStimulus(3, 1'b0);
        applyStimulus(3, 1'b0);
        checkOutput("t4_y48_base", y_base, 8'h30);
        checkOutput("t4_y48_wrap", y_wrap, 8'h30);
        checkOutput("t4_y48_shift", y_shift, 8'h0C);
        applyStimulus(3, 1'b0);
        checkOutput("t4_steady_shift", y_shift, 8'h0C);

        // Test 5: reload from a nonzero output; load raised on the last capture edge is ignored
        applyStimulus(9, 1'b1);
        checkOutput("t5_reload_cl", {7'd0, cl_base}, 8'h00);
        checkOutput("t5_reload_y", y_base, 8'h00);
        checkOutput("t5_reload_y_shift", y_shift, 8'h00);
        loadCoeffs(1, 0, 0, 0, 3);
        checkOutput("t5_cl", {7'd0, cl_base}, 8'h01);
        applyStimulus(7, 1'b0);
        checkOutput("t5_y0", y_base, 8'h00);
        applyStimulus(-5, 1'b0);
        checkOutput("t5_y7", y_base, 8'h07);
        applyStimulus(20, 1'b0);
        checkOutput("t5_ym5", y_base, 8'hFB);
        applyStimulus(0, 1'b0);
        checkOutput("t5_y20", y_base, 8'h14);

        // Test 6a: asynchronous reset between edges while running
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_run_rst_y", y_base, 8'h00);
        checkOutput("t6_run_rst_cl", {7'd0, cl_base}, 8'h00);
        #2;
        reset = 1'b0;

        // Test 6b: asynchronous reset after two captures, then a full reload from coeff[0]
        applyStimulus(9, 1'b0);
        applyStimulus(9, 1'b0);
        checkOutput("t6_midload_cl", {7'd0, cl_base}, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_load_rst_y", y_base, 8'h00);
        checkOutput("t6_load_rst_cl", {7'd0, cl_base}, 8'h00);
        #2;
        reset = 1'b0;
        loadCoeffs(3, 0, 0, 0, -1);
        checkOutput("t6_reload_cl", {7'd0, cl_base}, 8'h01);
        applyStimulus(2, 1'b0);
        checkOutput("t6_y0", y_base, 8'h00);
        applyStimulus(0, 1'b0);
        checkOutput("t6_y6", y_base, 8'h06);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
